// File: rtl/btn_dir_ctrl.sv
// Push-button front end: polarity fix, 2-flop synchroniser, debounce FSM,
// single-cycle press/release/long-press strobes and a press-toggled direction level.
module btn_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic dir
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] D_LAST   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(LONG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] L_MAX    = CNT_W'(LONG_CYCLES);
  localparam bit               D_ONE    = (DEBOUNCE_CYCLES == 32'd1);

  logic [1:0]       sync_r;
  logic             s_s;
  logic [1:0]       state_r, state_s;
  logic [CNT_W-1:0] deb_cnt_r, deb_cnt_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic             long_done_r, long_done_s;
  logic             level_s, dir_s;
  logic             press_evt_s, release_evt_s, long_evt_s;

  // Synchroniser; reset loads the released level so a held button must re-qualify.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_raw ^ ACTIVE_LOW};
    end
  end

  assign s_s = sync_r[1];

  // Next-state logic; press/release events override the per-state updates.
  always_comb begin
    state_s       = state_r;
    deb_cnt_s     = deb_cnt_r;
    hold_cnt_s    = hold_cnt_r;
    long_done_s   = long_done_r;
    level_s       = btn_level;
    dir_s         = dir;
    press_evt_s   = 1'b0;
    release_evt_s = 1'b0;
    long_evt_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (s_s) begin
          if (D_ONE) begin
            press_evt_s = 1'b1;
          end else begin
            state_s   = PRESS_WAIT;
            deb_cnt_s = CNT_ONE;
          end
        end else begin
          deb_cnt_s = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!s_s) begin
          state_s   = IDLE;
          deb_cnt_s = CNT_ZERO;
        end else if (deb_cnt_r == D_LAST) begin
          press_evt_s = 1'b1;
        end else begin
          deb_cnt_s = deb_cnt_r + CNT_ONE;
        end
      end
      HELD: begin
        if (!s_s && D_ONE) begin
          release_evt_s = 1'b1;
        end else begin
          // long_done keeps a bounce back into HELD from re-firing the strobe
          if (hold_cnt_r == L_LAST && !long_done_r) begin
            long_evt_s  = 1'b1;
            long_done_s = 1'b1;
          end else begin
            long_evt_s  = 1'b0;
          end
          if (hold_cnt_r != L_MAX) begin
            hold_cnt_s = hold_cnt_r + CNT_ONE;
          end else begin
            hold_cnt_s = hold_cnt_r;
          end
          if (!s_s) begin
            state_s   = RELEASE_WAIT;
            deb_cnt_s = CNT_ONE;
          end else begin
            deb_cnt_s = CNT_ZERO;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s_s) begin
          state_s   = HELD;
          deb_cnt_s = CNT_ZERO;
        end else if (deb_cnt_r == D_LAST) begin
          release_evt_s = 1'b1;
        end else begin
          deb_cnt_s = deb_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s   = IDLE;
        deb_cnt_s = CNT_ZERO;
      end
    endcase

    if (press_evt_s) begin
      state_s     = HELD;
      deb_cnt_s   = CNT_ZERO;
      hold_cnt_s  = CNT_ZERO;
      long_done_s = 1'b0;
      level_s     = 1'b1;
      dir_s       = ~dir;
    end else if (release_evt_s) begin
      state_s    = IDLE;
      deb_cnt_s  = CNT_ZERO;
      hold_cnt_s = CNT_ZERO;
      level_s    = 1'b0;
    end else begin
      level_s    = btn_level;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      deb_cnt_r     <= CNT_ZERO;
      hold_cnt_r    <= CNT_ZERO;
      long_done_r   <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      dir           <= 1'b0;
    end else begin
      state_r       <= state_s;
      deb_cnt_r     <= deb_cnt_s;
      hold_cnt_r    <= hold_cnt_s;
      long_done_r   <= long_done_s;
      btn_level     <= level_s;
      press_pulse   <= press_evt_s;
      release_pulse <= release_evt_s;
      long_pulse    <= long_evt_s;
      dir           <= dir_s;
    end
  end

endmodule

// File: tb/tb_btn_dir_ctrl.sv
// Bench for btn_dir_ctrl: active-high and active-low instances driven with the same
// button, checked every cycle against a run-length reference model plus directed timing checks.
module tb_btn_dir_ctrl;

  localparam int D  = 4;
  localparam int L  = 20;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic raw_h;
  logic raw_l;
  logic lvl_h, prs_h, rel_h, lng_h, dir_h;
  logic lvl_l, prs_l, rel_l, lng_l, dir_l;

  assign raw_l = ~raw_h;

  always #5 clk = ~clk;

  btn_dir_ctrl #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0), .CNT_W(CW)) u_hi (
    .clk(clk), .rst(rst), .btn_raw(raw_h), .btn_level(lvl_h), .press_pulse(prs_h),
    .release_pulse(rel_h), .long_pulse(lng_h), .dir(dir_h));

  btn_dir_ctrl #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1), .CNT_W(CW)) u_lo (
    .clk(clk), .rst(rst), .btn_raw(raw_l), .btn_level(lvl_l), .press_pulse(prs_l),
    .release_pulse(rel_l), .long_pulse(lng_l), .dir(dir_l));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model: accepted level plus length of the current disagreeing run
  logic m_pipe0, m_pipe1, m_lvl, m_dir, m_done, m_p, m_r, m_lg;
  int   m_run, m_held;

  // observed history of the active-high instance
  int n_press = 0, n_release = 0, n_long = 0;
  int last_press = -1, last_release = -1, last_long = -1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic raw_v, input logic rst_v);
    logic s_v;
    logic in_held;
    m_p = 1'b0; m_r = 1'b0; m_lg = 1'b0;
    if (rst_v) begin
      m_pipe0 = 1'b0; m_pipe1 = 1'b0; m_lvl = 1'b0; m_dir = 1'b0; m_done = 1'b0;
      m_run = 0; m_held = 0;
    end else begin
      s_v     = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = raw_v;
      in_held = m_lvl && (m_run == 0);
      if (in_held && !(s_v == 1'b0 && D == 1)) begin
        if (m_held == L - 1 && !m_done) begin
          m_lg = 1'b1; m_done = 1'b1;
        end
        m_held++;
      end
      if (s_v != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_run = 0;
          m_lvl = s_v;
          m_held = 0;
          if (s_v) begin
            m_p = 1'b1; m_dir = ~m_dir; m_done = 1'b0;
          end else begin
            m_r = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("lvl_h", lvl_h, m_lvl);  chk("lvl_l", lvl_l, m_lvl);
    chk("prs_h", prs_h, m_p);    chk("prs_l", prs_l, m_p);
    chk("rel_h", rel_h, m_r);    chk("rel_l", rel_l, m_r);
    chk("lng_h", lng_h, m_lg);   chk("lng_l", lng_l, m_lg);
    chk("dir_h", dir_h, m_dir);  chk("dir_l", dir_l, m_dir);
    chk("excl", (32'(prs_h) + 32'(rel_h) + 32'(lng_h)) <= 1, 1'b1);
    if (prs_h === 1'b1) begin n_press++;   last_press   = cyc; end
    if (rel_h === 1'b1) begin n_release++; last_release = cyc; end
    if (lng_h === 1'b1) begin n_long++;    last_long    = cyc; end
  endtask

  // drive after the falling edge, model at the rising edge, compare at the next falling edge
  task automatic step(input logic raw_v, input logic rst_v);
    raw_h = raw_v;
    rst   = rst_v;
    @(posedge clk);
    cyc++;
    model_edge(raw_v, rst_v);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n0, r0, l0, start, lev, len;
    raw_h = 1'b0;
    rst   = 1'b1;
    m_pipe0 = 1'b0; m_pipe1 = 1'b0; m_lvl = 1'b0; m_dir = 1'b0; m_done = 1'b0;
    m_p = 1'b0; m_r = 1'b0; m_lg = 1'b0; m_run = 0; m_held = 0;

    repeat (3) step(1'b0, 1'b1);
    chk("rst_lvl", lvl_h, 1'b0);
    chk("rst_dir", dir_l, 1'b0);

    // 1: clean press from edge 10, held 10 cycles
    while (cyc < 9) step(1'b0, 1'b0);
    n0 = n_press; l0 = n_long; start = cyc + 1;
    repeat (10) step(1'b1, 1'b0);
    chk_int("s1_press_edge", last_press, start + D + 1);
    chk_int("s1_press_cnt", n_press - n0, 1);
    chk_int("s1_no_long", n_long - l0, 0);
    chk("s1_dir", dir_h, 1'b1);
    chk("s1_level", lvl_h, 1'b1);
    r0 = n_release;
    repeat (8) step(1'b0, 1'b0);
    chk_int("s1_release_cnt", n_release - r0, 1);

    // 2: bounce 1-1-0-1-1-0 then stable
    repeat (2) step(1'b0, 1'b1);
    n0 = n_press;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    start = cyc + 1;
    repeat (12) step(1'b1, 1'b0);
    chk_int("s2_press_cnt", n_press - n0, 1);
    chk_int("s2_press_edge", last_press, start + D + 1);
    chk("s2_dir", dir_h, 1'b1);
    repeat (8) step(1'b0, 1'b0);

    // 3: long hold of 40 cycles, then release
    repeat (2) step(1'b0, 1'b1);
    l0 = n_long; r0 = n_release;
    repeat (40) step(1'b1, 1'b0);
    chk_int("s3_long_cnt", n_long - l0, 1);
    chk_int("s3_long_delay", last_long - last_press, L);
    repeat (8) step(1'b0, 1'b0);
    chk_int("s3_release_cnt", n_release - r0, 1);
    chk_int("s3_long_after_rel", n_long - l0, 1);
    chk("s3_dir", dir_h, 1'b1);

    // 4: two full press/release cycles
    repeat (2) step(1'b0, 1'b1);
    n0 = n_press; r0 = n_release;
    repeat (8) step(1'b1, 1'b0);
    chk("s4_dir1", dir_h, 1'b1);
    repeat (8) step(1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    chk("s4_dir2", dir_h, 1'b0);
    chk_int("s4_press_cnt", n_press - n0, 2);
    chk_int("s4_release_cnt", n_release - r0, 2);

    // 5: reset mid-PRESS_WAIT, then mid-HELD, button kept down
    repeat (2) step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("s5_rst1_lvl", lvl_h, 1'b0);
    start = cyc + 1;
    repeat (10) step(1'b1, 1'b0);
    chk_int("s5_requal_edge", last_press, start + D + 1);
    chk("s5_dir_held", dir_h, 1'b1);
    step(1'b1, 1'b1);
    chk("s5_rst2_dir", dir_h, 1'b0);
    chk("s5_rst2_dir_l", dir_l, 1'b0);
    start = cyc + 1;
    repeat (10) step(1'b1, 1'b0);
    chk_int("s5_requal2_edge", last_press, start + D + 1);
    repeat (8) step(1'b0, 1'b0);

    // random bursts with occasional reset
    for (int i = 0; i < 60; i++) begin
      lev = int'($urandom_range(1, 0));
      len = int'($urandom_range(40, 1));
      if ($urandom_range(19, 0) == 0) begin
        step(1'(lev), 1'b1);
      end
      for (int k = 0; k < len; k++) begin
        step(1'(lev), 1'b0);
      end
    end
    repeat (10) step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
